// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding,
// requester count, data width and a one-hot helper.
package mux_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 2;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set request bit starting at
// last+1 and wrapping modulo 4, so the previous winner is examined last.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic               found,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 x 2-bit mux among four requesters.
// Define ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant cycles.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [DATA_W-1:0]   d0,
    input  logic [DATA_W-1:0]   d1,
    input  logic [DATA_W-1:0]   d2,
    input  logic [DATA_W-1:0]   d3,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   y,
    output logic                valid
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range
        $error("mux_rr_arbiter: HOLD_MAX must lie in 2..255");
    end

    arb_state_t         state;
    logic [1:0]         last;
    logic [NUM_REQ-1:0] srch_req;
    logic               found;
    logic [1:0]         win;
    logic               do_grant;
    logic               do_drop;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       hold_expired;

    assign hold_expired = (hold_cnt == 8'(HOLD_MAX - 1));
`endif

    // The current owner is masked so a pending "other" request is exactly
    // what the picker reports; this also ranks a releasing owner last.
    assign srch_req = req & ~gnt;

    rr_pick4 u_pick (
        .req   (srch_req),
        .last  (last),
        .found (found),
        .idx   (win)
    );

    always_comb begin
        do_grant = 1'b0;
        do_drop  = 1'b0;
        if (state == IDLE) begin
            do_grant = found;
        end else if (!req[sel]) begin
            do_grant = found;
            do_drop  = !found;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
            do_grant = found && hold_expired;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= 2'd0;
            valid <= 1'b0;
            last  <= 2'd3;
        end else if (do_grant) begin
            state <= BUSY;
            gnt   <= onehot4(win);
            sel   <= win;
            valid <= 1'b1;
            last  <= win;
        end else if (do_drop) begin
            // sel is kept so it still names the last grantee while idle
            state <= IDLE;
            gnt   <= '0;
            valid <= 1'b0;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (do_grant) begin
            hold_cnt <= 8'd0;
        end else if (state == BUSY && !hold_expired) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        y = '0;
        if (valid) begin
            case (sel)
                2'd0: y = d0;
                2'd1: y = d1;
                2'd2: y = d2;
                2'd3: y = d3;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter; builds with or without ARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] d [4];
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] y;
    logic       valid;

    int nvec = 0;
    int nerr = 0;

    // reference state: owner index (-1 when idle), last grantee shown on sel,
    // round-robin pointer, and number of edges the owner has held the grant
    int m_own, m_sel, m_last, m_held;

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .d0    (d[0]),
        .d1    (d[1]),
        .d2    (d[2]),
        .d3    (d[3]),
        .gnt   (gnt),
        .sel   (sel),
        .y     (y),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_own  = -1;
        m_sel  = 0;
        m_last = 3;
        m_held = 0;
    endtask

    task automatic model_edge(input logic [3:0] r);
        int nxt;
        bit keep;
        nxt = -1;
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (nxt < 0 && r[c] && c != m_own) nxt = c;
        end
        keep = (m_own >= 0) && r[m_own] && !(TO_EN && m_held >= HOLD && nxt >= 0);
        if (keep) begin
            m_held++;
        end else if (nxt >= 0) begin
            m_own  = nxt;
            m_sel  = nxt;
            m_last = nxt;
            m_held = 1;
        end else begin
            m_own = -1;
        end
    endtask

    function automatic logic [3:0] exp_gnt();
        return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
    endfunction

    function automatic logic [1:0] exp_y();
        return (m_own < 0) ? 2'b00 : d[m_sel];
    endfunction

    task automatic tick();
        model_edge(req);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 4; i++) d[i] = 2'(i);
        #2;
        nvec++;
        if (gnt !== 4'b0000 || sel !== 2'b00 || valid !== 1'b0 || y !== 2'b00) begin
            nerr++;
            $display("FAIL reset_state: gnt=%b sel=%b valid=%b y=%b, want 0000/00/0/00", gnt, sel, valid, y);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req = 4'b1111;
        tick();
        nvec++;
        if (gnt !== 4'b0001 || valid !== 1'b1) begin
            nerr++;
            $display("FAIL reset_first_grant: gnt=%b valid=%b, want 0001/1", gnt, valid);
        end
        #3;
        rst = 1'b1;
        #1;
        nvec++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || y !== 2'b00 || sel !== 2'b00) begin
            nerr++;
            $display("FAIL reset_async: gnt=%b valid=%b y=%b sel=%b, want 0000/0/00/00", gnt, valid, y, sel);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        req = 4'b0001;
        tick();
        nvec++;
        if (gnt !== 4'b0001) begin
            nerr++;
            $display("FAIL reset_regrant: gnt=%b, want 0001", gnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        d[2] = 2'b10;
        req  = 4'b0100;
        tick();
        nvec++;
        if (gnt !== 4'b0100 || sel !== 2'b10 || y !== 2'b10 || valid !== 1'b1) begin
            nerr++;
            $display("FAIL single_grant: gnt=%b sel=%b y=%b valid=%b, want 0100/10/10/1", gnt, sel, y, valid);
        end
        req = 4'b0000;
        tick();
        nvec++;
        if (gnt !== 4'b0000 || sel !== 2'b10 || valid !== 1'b0 || y !== 2'b00) begin
            nerr++;
            $display("FAIL single_release: gnt=%b sel=%b valid=%b y=%b, want 0000/10/0/00", gnt, sel, valid, y);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        apply_reset();
        req = 4'b1111;
        tick();
        nvec++;
        if (gnt !== order[0]) begin
            nerr++;
            $display("FAIL fair_grant0: gnt=%b, want %b", gnt, order[0]);
        end
        for (int i = 1; i < 5; i++) begin
            req = 4'b1111 & ~order[i-1];
            tick();
            nvec++;
            if (gnt !== order[i] || valid !== 1'b1) begin
                nerr++;
                $display("FAIL fair_handover%0d: gnt=%b valid=%b, want %b/1", i, gnt, valid, order[i]);
            end
            req = 4'b1111;
            tick();
            nvec++;
            if (gnt !== order[i]) begin
                nerr++;
                $display("FAIL fair_hold%0d: gnt=%b, want %b", i, gnt, order[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 4'b1001;
        tick();
        nvec++;
        if (gnt !== 4'b0001) begin
            nerr++;
            $display("FAIL wrap_last3: gnt=%b, want 0001", gnt);
        end
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        nvec++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            nerr++;
            $display("FAIL wrap_last0: gnt=%b sel=%b, want 1000/11", gnt, sel);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] want;
        apply_reset();
        req = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            tick();
            want = (TO_EN && ((c / HOLD) % 2 == 1)) ? 4'b0010 : 4'b0001;
            nvec++;
            if (gnt !== want || gnt !== exp_gnt()) begin
                nerr++;
                $display("FAIL timeout_cyc%0d: gnt=%b, want %b (model %b)", c, gnt, want, exp_gnt());
            end
        end
    endtask

    task automatic test_datapath();
        logic [1:0] v;
        apply_reset();
        for (int i = 0; i < 4; i++) d[i] = 2'b00;
        req = 4'b0010;
        tick();
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            d[1] = v;
            #1;
            nvec++;
            if (y !== v) begin
                nerr++;
                $display("FAIL data_follow%0d: y=%b, want %b", i, y, v);
            end
        end
        for (int i = 0; i < 3; i++) begin
            d[0] = 2'($urandom);
            d[2] = 2'($urandom);
            d[3] = 2'($urandom);
            #1;
            nvec++;
            if (y !== 2'b11) begin
                nerr++;
                $display("FAIL data_isolate%0d: y=%b, want 11", i, y);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 4) req = 4'($urandom);
            else if ($urandom_range(0, 9) < 2) req = req & ~gnt;
            for (int i = 0; i < 4; i++) d[i] = 2'($urandom);
            tick();
            nvec++;
            if (gnt !== exp_gnt() || valid !== (m_own >= 0) || !$onehot0(gnt)) begin
                nerr++;
                $display("FAIL rand_gnt c%0d: gnt=%b valid=%b, want %b/%0d", c, gnt, valid, exp_gnt(), m_own >= 0);
            end
            nvec++;
            if (sel !== 2'(m_sel) || y !== exp_y()) begin
                nerr++;
                $display("FAIL rand_sel_y c%0d: sel=%0d y=%b, want %0d/%b", c, sel, y, m_sel, exp_y());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_datapath();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
